ml605_clken_gen: RTL
====================

ML605_CLKEN_GEN -- requirements
Module: ml605_clken_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent clock-enable channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 16: divisor width in bits.
REQ-003 SHALL have parameter DIV_RST, default 2: divisor loaded into every channel at reset.
REQ-004 clk_200  in  1  single 200 MHz system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 ch_en  in  NUM_CH  per-channel run enable.
REQ-007 cfg_valid  in  1  divisor update request.
REQ-008 cfg_ready  out  1  update slot free.
REQ-009 cfg_ch  in  max(1,clog2(NUM_CH))  target channel of update.
REQ-010 cfg_div  in  DIV_W  new divisor.
REQ-011 clk_en  out  NUM_CH  one-cycle enable strobe per channel.
REQ-012 clk_sq  out  NUM_CH  50%-duty square wave per channel, period 2*D cycles.

Function
REQ-013 Each channel SHALL hold a counter cnt (DIV_W bits) and active divisor D.
REQ-014 While ch_en[i]=1 and D>=1, cnt SHALL increment each cycle and wrap to 0 on the cycle after cnt==D-1.
REQ-015 clk_en[i] SHALL be registered and high for exactly the one cycle after each wrap; otherwise low.
REQ-016 clk_sq[i] SHALL toggle in the same cycle clk_en[i] is high.
REQ-017 After ch_en[i] rises (cnt=0), the first clk_en[i] SHALL occur exactly D cycles later, then every D cycles.
REQ-018 D=1: clk_en[i] SHALL stay high every enabled cycle; clk_sq[i] toggles every cycle.
REQ-019 D=0: channel SHALL be idle (cnt held 0, clk_en[i]=0, clk_sq[i]=0) regardless of ch_en[i].
REQ-020 ch_en[i]=0: cnt, clk_en[i], clk_sq[i] SHALL be 0 from the next cycle.
REQ-021 Update handshake: transfer occurs when cfg_valid && cfg_ready; cfg_ch/cfg_div captured into a single pending slot (valid, ch, div).
REQ-022 cfg_ready SHALL be ~pending_valid; cfg_ready is not combinationally dependent on cfg_valid.
REQ-023 A pending update SHALL be applied to its channel's D on that channel's next wrap, or on the next cycle if that channel is disabled or D=0; pending_valid clears in the same cycle.
REQ-024 A transfer coinciding with a wrap of the target channel SHALL NOT apply at that wrap; it waits for the following wrap.
REQ-025 A transfer with cfg_ch>=NUM_CH SHALL be accepted and discarded (pending_valid not set).
REQ-026 Divisor changes SHALL never produce a strobe interval other than old D or new D (glitch-free).

Reset
REQ-027 On rst=1 (any cycle, incl. mid-count or mid-update): cnt=0, D=DIV_RST, clk_en=0, clk_sq=0, pending_valid=0 (pending update discarded), cfg_ready=1, all on the next edge.
REQ-028 rst SHALL take priority over all other inputs including sync_req.

Configuration
REQ-029 Macro CLKEN_GEN_PHASE_ALIGN_EN, when defined, SHALL add input sync_req (1 bit).
REQ-030 With it: sync_req=1 SHALL set every cnt to 0, clk_sq to 0 and suppress clk_en in the next cycle, taking priority over wrap; pending update then applies immediately to its channel.
REQ-031 Without it: no sync_req port; channels run free-phase; all other behaviour identical.

Structure
REQ-032 Shared package ml605_clkgen_pkg SHALL hold NUM_CH/DIV_W/DIV_RST defaults and the pending-slot record type.
REQ-033 Per-channel counter/strobe/square logic SHALL be sub-module ml605_clken_ch, instantiated NUM_CH times; handshake and pending slot live in the top.

Verification
REQ-034 Reset, ch_en=4'b0001, D=2 -> clk_en[0] high at cycles 2,4,6 after enable; clk_sq[0] period 4; other channels 0.
REQ-035 Ch1 running D=5, transfer cfg_div=3 mid-count -> intervals 5,...,5 then 3 from the wrap after transfer; cfg_ready low until applied.
REQ-036 Transfer to ch2 on the exact cycle ch2 wraps (D=4, new 7) -> next interval 4, then 7.
REQ-037 Set D=1 on ch0, D=0 on ch3 with ch_en=4'b1111 -> clk_en[0] constant high, ch3 outputs constant 0; cfg_ch=5 transfer -> discarded, cfg_ready stays 1.
REQ-038 rst asserted with pending update and running counters -> all outputs 0, D=2 everywhere, cfg_ready=1 next cycle.
REQ-039 With CLKEN_GEN_PHASE_ALIGN_EN, ch0 D=3 and ch1 D=6 out of phase, pulse sync_req -> both strobe 3 and 6 cycles later, coincident every 6 cycles.

Source files
------------

// File: rtl/ml605_clkgen_pkg.sv
// ml605_clkgen_pkg: default parameters and the pending divisor-update record
// shared by ml605_clken_gen and its per-channel sub-module.
package ml605_clkgen_pkg;

    localparam int NUM_CH_DEF  = 4;
    localparam int DIV_W_DEF   = 16;
    localparam int DIV_RST_DEF = 2;

    // Record fields are sized for the largest legal configuration (16 channels, 32-bit divisor).
    localparam int CH_W_MAX    = 4;
    localparam int DIV_W_MAX   = 32;

    typedef struct packed {
        logic                 valid;
        logic [CH_W_MAX-1:0]  ch;
        logic [DIV_W_MAX-1:0] div;
    } pend_slot_t;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ml605_clken_ch.sv
// ml605_clken_ch: one divide-by-D clock-enable channel producing a one-cycle
// strobe every D cycles and a square wave that toggles on each strobe.
module ml605_clken_ch
    import ml605_clkgen_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic             clk_200,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_div,
    output logic             o_wrap,
    output logic             o_idle,
    output logic             o_clk_en,
    output logic             o_clk_sq
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_clk_en;
    logic             r_clk_sq;
    logic             w_run;
    logic             w_hit;

    assign w_run    = i_en && (r_div != '0);
    assign w_hit    = (r_cnt == (r_div - DIV_W'(1)));
    assign o_wrap   = w_run && w_hit && !i_sync;
    assign o_idle   = !w_run;
    assign o_clk_en = r_clk_en;
    assign o_clk_sq = r_clk_sq;

    // A new divisor only ever lands at a wrap or while idle, so cnt is 0 when it takes effect.
    always_ff @(posedge clk_200) begin
        if (rst) begin
            r_cnt    <= '0;
            r_div    <= DIV_W'(DIV_RST);
            r_clk_en <= 1'b0;
            r_clk_sq <= 1'b0;
        end else begin
            if (i_load) begin
                r_div <= i_load_div;
            end
            if (i_sync || !w_run) begin
                r_cnt    <= '0;
                r_clk_en <= 1'b0;
                r_clk_sq <= 1'b0;
            end else if (w_hit) begin
                r_cnt    <= '0;
                r_clk_en <= 1'b1;
                r_clk_sq <= ~r_clk_sq;
            end else begin
                r_cnt    <= r_cnt + DIV_W'(1);
                r_clk_en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ml605_clken_gen.sv
// ml605_clken_gen: NUM_CH independent clock-enable generators with a single-slot
// divisor update handshake. Define CLKEN_GEN_PHASE_ALIGN_EN to add the sync_req phase-align input.
module ml605_clken_gen
    import ml605_clkgen_pkg::*;
#(
    parameter  int NUM_CH  = NUM_CH_DEF,
    parameter  int DIV_W   = DIV_W_DEF,
    parameter  int DIV_RST = DIV_RST_DEF,
    localparam int CH_W    = ch_idx_w(NUM_CH)
) (
    input  logic              clk_200,
    input  logic              rst,
`ifdef CLKEN_GEN_PHASE_ALIGN_EN
    input  logic              sync_req,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] clk_sq
);

    pend_slot_t        r_pend;
    logic              w_sync;
    logic              w_ch_ok;
    logic              w_unused;
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_idle;
    logic [NUM_CH-1:0] w_apply;

`ifdef CLKEN_GEN_PHASE_ALIGN_EN
    assign w_sync = sync_req;
`else
    assign w_sync = 1'b0;
`endif

    assign w_ch_ok   = (int'(cfg_ch) < NUM_CH);
    assign cfg_ready = ~r_pend.valid;
    assign w_unused  = ^r_pend.div;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_apply[gi] = r_pend.valid && (r_pend.ch == CH_W_MAX'(gi)) &&
                             (w_wrap[gi] || w_idle[gi] || w_sync);

        ml605_clken_ch #(
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk_200    (clk_200),
            .rst        (rst),
            .i_en       (ch_en[gi]),
            .i_sync     (w_sync),
            .i_load     (w_apply[gi]),
            .i_load_div (r_pend.div[DIV_W-1:0]),
            .o_wrap     (w_wrap[gi]),
            .o_idle     (w_idle[gi]),
            .o_clk_en   (clk_en[gi]),
            .o_clk_sq   (clk_sq[gi])
        );
    end

    // Updates aimed at a non-existent channel are acknowledged but never occupy the slot.
    always_ff @(posedge clk_200) begin
        if (rst) begin
            r_pend <= '0;
        end else if (r_pend.valid) begin
            if (|w_apply) begin
                r_pend.valid <= 1'b0;
            end
        end else if (cfg_valid && w_ch_ok) begin
            r_pend.valid <= 1'b1;
            r_pend.ch    <= CH_W_MAX'(cfg_ch);
            r_pend.div   <= DIV_W_MAX'(cfg_div);
        end
    end

endmodule
